// File: rtl/tc_acc_buf.sv
// tc_acc_buf: M x N signed accumulator buffer fed by TILE_M x TILE_N partial-product tiles, drained row by row.
// Latency: a write lands in storage 1 cycle later; a row request returns registered data 1 cycle later.
// Backpressure: none. Writes and reads are accepted every cycle, and illegal requests are dropped and flagged in err.
// Optional feature: define TC_ACC_SATURATE_EN to saturate each accumulate and report clamping on sat.
module tc_acc_buf #(
  parameter int M      = 16,
  parameter int N      = 16,
  parameter int TILE_M = 4,
  parameter int TILE_N = 4,
  parameter int DW_ACC = 32
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              clear,
  input  logic                              write_d,
  input  logic [3:0]                        ptr_m,
  input  logic [3:0]                        ptr_n,
  input  logic [TILE_M*TILE_N*DW_ACC-1:0]   tile_d,
  input  logic                              out_valid,
  input  logic [3:0]                        row_out,
  output logic [N*DW_ACC-1:0]               row_data,
  output logic                              row_valid,
  output logic [3:0]                        row_idx,
  output logic                              done,
  output logic                              err,
  output logic                              sat
);

  typedef enum logic [1:0] {ST_IDLE, ST_ACC, ST_DRAIN} state_t;

  state_t                r_state;
  logic [DW_ACC-1:0]     r_acc [M][N];
  logic [N*DW_ACC-1:0]   r_row_data;
  logic                  r_row_valid;
  logic [3:0]            r_row_idx;
  logic                  r_done;
  logic                  r_err;

  logic                  w_wr_ok;
  logic                  w_rd_ok;
  logic                  w_err_evt;
  logic [3:0]            w_base_m;
  logic [3:0]            w_base_n;
  logic [DW_ACC-1:0]     w_old;
  logic [DW_ACC-1:0]     w_add;
  logic [DW_ACC-1:0]     w_new [TILE_M][TILE_N];

`ifdef TC_ACC_SATURATE_EN
  localparam logic [DW_ACC-1:0] ACC_MAX = {1'b0, {(DW_ACC-1){1'b1}}};
  localparam logic [DW_ACC-1:0] ACC_MIN = {1'b1, {(DW_ACC-1){1'b0}}};
  logic [DW_ACC:0]       w_sum;
  logic                  w_clamp;
  logic                  r_sat;
`endif

  // Decide which of this cycle's requests are legal; anything dropped is an error event
  always_comb begin
    w_wr_ok = write_d && (r_state != ST_DRAIN)
              && (int'(ptr_m) <= M - TILE_M) && (int'(ptr_n) <= N - TILE_N)
              && ((int'(ptr_m) % TILE_M) == 0) && ((int'(ptr_n) % TILE_N) == 0);
    w_rd_ok = out_valid && (int'(row_out) < M) && (r_state != ST_IDLE);
    w_err_evt = (write_d && !w_wr_ok) || (out_valid && !w_rd_ok);
  end

  // Per-element tile sums; the base is forced to 0 on an illegal write so indices never leave the array
  always_comb begin
    w_base_m = w_wr_ok ? ptr_m : 4'd0;
    w_base_n = w_wr_ok ? ptr_n : 4'd0;
    w_old    = '0;
    w_add    = '0;
`ifdef TC_ACC_SATURATE_EN
    w_sum    = '0;
    w_clamp  = 1'b0;
`endif
    for (int i = 0; i < TILE_M; i++) begin
      for (int j = 0; j < TILE_N; j++) begin
        w_old = r_acc[w_base_m + 4'(i)][w_base_n + 4'(j)];
        w_add = tile_d[(i*TILE_N+j)*DW_ACC +: DW_ACC];
`ifdef TC_ACC_SATURATE_EN
        // One extra bit: overflow shows up as the top two bits disagreeing
        w_sum = {w_old[DW_ACC-1], w_old} + {w_add[DW_ACC-1], w_add};
        if (w_sum[DW_ACC] != w_sum[DW_ACC-1]) begin
          w_clamp     = 1'b1;
          w_new[i][j] = w_sum[DW_ACC] ? ACC_MIN : ACC_MAX;
        end else begin
          w_new[i][j] = w_sum[DW_ACC-1:0];
        end
`else
        w_new[i][j] = w_old + w_add;
`endif
      end
    end
  end

  // Accumulator array: zeroed by reset/clear, tile read-modify-write on an accepted write
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      for (int r = 0; r < M; r++) begin
        for (int c = 0; c < N; c++) begin
          r_acc[r][c] <= '0;
        end
      end
    end else if (w_wr_ok) begin
      for (int i = 0; i < TILE_M; i++) begin
        for (int j = 0; j < TILE_N; j++) begin
          r_acc[w_base_m + 4'(i)][w_base_n + 4'(j)] <= w_new[i][j];
        end
      end
    end
  end

  // Control FSM and registered read port; the read samples the array before this cycle's write lands
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_row_data  <= '0;
      r_row_valid <= 1'b0;
      r_row_idx   <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else if (clear) begin
      // Row data and index keep their last values; only the strobes drop
      r_state     <= ST_IDLE;
      r_row_valid <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_row_valid <= w_rd_ok;
      r_done      <= w_rd_ok && (int'(row_out) == M - 1);
      r_err       <= r_err || w_err_evt;
      if (w_rd_ok) begin
        r_row_idx <= row_out;
        for (int c = 0; c < N; c++) begin
          r_row_data[c*DW_ACC +: DW_ACC] <= r_acc[row_out][c];
        end
      end
      // A read moves the FSM toward drain even if a write is accepted alongside it
      if (w_rd_ok) begin
        r_state <= (int'(row_out) == M - 1) ? ST_IDLE : ST_DRAIN;
      end else if (w_wr_ok) begin
        r_state <= ST_ACC;
      end
    end
  end

`ifdef TC_ACC_SATURATE_EN
  // Sticky saturation flag, raised when any element of an accepted write was clamped
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_sat <= 1'b0;
    end else if (w_wr_ok && w_clamp) begin
      r_sat <= 1'b1;
    end
  end
  assign sat = r_sat;
`else
  assign sat = 1'b0;
`endif

  assign row_data  = r_row_data;
  assign row_valid = r_row_valid;
  assign row_idx   = r_row_idx;
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_tc_acc_buf.sv
// tb_tc_acc_buf: directed test-plan steps followed by a randomized phase.
// Every cycle is compared against a behavioural model of the accumulator buffer.
module tb_tc_acc_buf;

  logic          clk = 1'b0;
  logic          reset, clear, write_d, out_valid;
  logic [3:0]    ptr_m, ptr_n, row_out;
  logic [511:0]  tile_d;
  logic [511:0]  row_data;
  logic          row_valid, done, err, sat;
  logic [3:0]    row_idx;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0]   m_acc [16][16];
  int            m_state;      // 0 idle, 1 accumulating, 2 draining
  logic          m_err, m_sat, m_rv, m_done;
  logic [3:0]    m_ridx;
  logic [511:0]  m_rdata;

  tc_acc_buf dut (
    .clk(clk), .reset(reset), .clear(clear), .write_d(write_d),
    .ptr_m(ptr_m), .ptr_n(ptr_n), .tile_d(tile_d),
    .out_valid(out_valid), .row_out(row_out),
    .row_data(row_data), .row_valid(row_valid), .row_idx(row_idx),
    .done(done), .err(err), .sat(sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] fill(input logic [31:0] v);
    logic [511:0] t;
    for (int k = 0; k < 16; k++) t[k*32 +: 32] = v;
    return t;
  endfunction

  function automatic logic [511:0] single(input logic [31:0] v);
    logic [511:0] t;
    t = '0;
    t[31:0] = v;
    return t;
  endfunction

  function automatic logic [511:0] rnd_tile();
    logic [511:0] t;
    for (int k = 0; k < 16; k++) begin
      if ($urandom_range(0, 15) == 0) t[k*32 +: 32] = 32'($urandom);
      else t[k*32 +: 32] = 32'($urandom_range(0, 2000)) - 32'd1000;
    end
    return t;
  endfunction

  function automatic void model_zero();
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) m_acc[r][c] = '0;
  endfunction

  // One clock: apply inputs, step the model by the buffer's rules, then compare after the edge
  task automatic cyc(input bit rst, input bit clr, input bit wr, input int pm, input int pn,
                     input logic [511:0] t, input bit ov, input int ro);
    bit rd_ok, wr_ok;
    longint s;
    reset = rst; clear = clr; write_d = wr; ptr_m = 4'(pm); ptr_n = 4'(pn);
    tile_d = t; out_valid = ov; row_out = 4'(ro);
    if (rst) begin
      model_zero();
      m_state = 0; m_err = 0; m_sat = 0; m_rv = 0; m_done = 0; m_ridx = '0; m_rdata = '0;
    end else if (clr) begin
      model_zero();
      m_state = 0; m_err = 0; m_sat = 0; m_rv = 0; m_done = 0;
    end else begin
      rd_ok = ov && ro < 16 && m_state != 0;
      wr_ok = wr && m_state != 2 && pm <= 12 && pn <= 12 && pm % 4 == 0 && pn % 4 == 0;
      if ((ov && !rd_ok) || (wr && !wr_ok)) m_err = 1;
      m_rv = rd_ok;
      m_done = rd_ok && ro == 15;
      if (rd_ok) begin
        m_ridx = 4'(ro);
        for (int c = 0; c < 16; c++) m_rdata[c*32 +: 32] = m_acc[ro][c];
      end
      if (wr_ok) begin
        for (int i = 0; i < 4; i++) begin
          for (int j = 0; j < 4; j++) begin
            s = longint'($signed(m_acc[pm+i][pn+j])) + longint'($signed(t[(i*4+j)*32 +: 32]));
`ifdef TC_ACC_SATURATE_EN
            if (s > 64'sd2147483647) begin s = 64'sd2147483647; m_sat = 1; end
            else if (s < -64'sd2147483648) begin s = -64'sd2147483648; m_sat = 1; end
`endif
            m_acc[pm+i][pn+j] = s[31:0];
          end
        end
      end
      if (rd_ok) m_state = (ro == 15) ? 0 : 2;
      else if (wr_ok) m_state = 1;
    end
    @(posedge clk);
    #1;
    chk("row_valid", row_valid, m_rv);
    chk("done", done, m_done);
    chk("err", err, m_err);
    chk("sat", sat, m_sat);
    chk("row_idx", row_idx, m_ridx);
    chk("row_data", row_data, m_rdata);
  endtask

  task automatic do_rst();                   cyc(1, 0, 0, 0, 0, '0, 0, 0); endtask
  task automatic do_clr();                   cyc(0, 1, 0, 0, 0, '0, 0, 0); endtask
  task automatic do_idle();                  cyc(0, 0, 0, 0, 0, '0, 0, 0); endtask
  task automatic do_wr(input int pm, input int pn, input logic [511:0] t); cyc(0, 0, 1, pm, pn, t, 0, 0); endtask
  task automatic do_rd(input int ro);        cyc(0, 0, 0, 0, 0, '0, 1, ro); endtask

  initial begin
    logic [511:0] t, exp_row;
    logic [31:0]  old;
    int nv;

    reset = 1; clear = 0; write_d = 0; out_valid = 0;
    ptr_m = '0; ptr_n = '0; row_out = '0; tile_d = '0;

    // Reset state
    do_rst();
    do_rst();
    chk("rst_row_data", row_data, 0);
    chk("rst_row_valid", row_valid, 0);
    chk("rst_row_idx", row_idx, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_sat", sat, 0);

    // Full sweep: 64 all-ones tile writes in (m,n,k) order, then rows 0..15 back to back
    for (int m = 0; m < 4; m++)
      for (int n = 0; n < 4; n++)
        for (int k = 0; k < 4; k++) do_wr(4*m, 4*n, fill(32'd1));
    nv = 0;
    for (int r = 0; r < 16; r++) begin
      do_rd(r);
      if (row_valid === 1'b1) nv++;
      chk("sweep_col0", row_data[31:0], 4);
      chk("sweep_col15", row_data[511:480], 4);
      chk("sweep_idx", row_idx, r);
      chk("sweep_done", done, (r == 15) ? 1 : 0);
    end
    do_idle();
    chk("sweep_valid_cycles", nv, 16);
    chk("sweep_done_single", done, 0);
    chk("sweep_err", err, 0);
    do_rd(0);                      // buffer is idle again, so this read is refused
    chk("idle_read_err", err, 1);
    chk("idle_read_valid", row_valid, 0);
    do_clr();
    chk("clear_err", err, 0);

    // Same-cycle write and read returns the pre-write value
    t = rnd_tile();
    do_wr(0, 0, t);
    old = t[31:0];
    cyc(0, 0, 1, 0, 0, single(32'd5), 1, 0);
    chk("rbw_old", row_data[31:0], old);
    do_rd(0);
    chk("rbw_new", row_data[31:0], old + 32'd5);
    do_rd(15);

    // Illegal writes: misaligned pointer, then a write while draining
    do_clr();
    t = rnd_tile();
    do_wr(4, 4, t);
    chk("illegal_pre_err", err, 0);
    do_wr(13, 0, fill(32'd7));
    chk("illegal_ptr_err", err, 1);
    do_rd(13);
    chk("illegal_row13", row_data, 0);
    exp_row = '0;
    for (int j = 0; j < 4; j++) exp_row[(4+j)*32 +: 32] = t[j*32 +: 32];
    do_wr(4, 4, fill(32'd9));
    do_rd(4);
    chk("illegal_row4", row_data, exp_row);
    chk("illegal_err_held", err, 1);
    do_clr();
    chk("illegal_clear_err", err, 0);

    // Clear beats a same-cycle write and read
    do_wr(0, 0, fill(32'd3));
    cyc(0, 1, 1, 0, 0, fill(32'd3), 1, 0);
    chk("clrpri_valid", row_valid, 0);
    do_rd(0);
    chk("clrpri_idle_err", err, 1);
    do_clr();
    do_wr(0, 0, '0);
    for (int r = 0; r < 16; r++) begin
      do_rd(r);
      chk("clrpri_zero", row_data, 0);
    end

    // Overflow at element (0,0)
    do_clr();
    do_wr(0, 0, single(32'h7FFF_FFFF));
    do_wr(0, 0, single(32'd1));
    do_rd(0);
`ifdef TC_ACC_SATURATE_EN
    chk("ovf_value", row_data[31:0], 32'h7FFF_FFFF);
    chk("ovf_sat", sat, 1);
`else
    chk("ovf_value", row_data[31:0], 32'h8000_0000);
    chk("ovf_sat", sat, 0);
`endif
    do_rd(15);

    // Reset in the middle of draining
    do_clr();
    do_wr(0, 0, rnd_tile());
    for (int r = 0; r <= 5; r++) do_rd(r);
    do_rst();
    chk("rstmid_row_data", row_data, 0);
    chk("rstmid_row_valid", row_valid, 0);
    chk("rstmid_row_idx", row_idx, 0);
    chk("rstmid_done", done, 0);
    chk("rstmid_err", err, 0);
    chk("rstmid_sat", sat, 0);
    do_rd(6);
    chk("rstmid_read_err", err, 1);
    chk("rstmid_read_valid", row_valid, 0);

    // Randomized traffic against the model
    do_rst();
    for (int n = 0; n < 600; n++) begin
      int pm, pn;
      bit wr, ov, clr;
      clr = ($urandom_range(0, 39) == 0);
      wr  = ($urandom_range(0, 1) == 1);
      ov  = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) begin
        pm = $urandom_range(0, 15);
        pn = $urandom_range(0, 15);
      end else begin
        pm = 4 * $urandom_range(0, 3);
        pn = 4 * $urandom_range(0, 3);
      end
      cyc(0, clr, wr, pm, pn, rnd_tile(), ov, $urandom_range(0, 15));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
